// File: rtl/ecc_check_stage.sv
// ecc_check_stage: two-stage SECDED check/correct pipeline with
// saturating error counters and a sticky first-error log.
//
// Ports:
//   clk_i, rst_i            clock, async active-high reset
//   valid_i/ready_o, cw_i   upstream handshake, {overall parity, codeword}
//   valid_o/ready_i         downstream handshake
//   data_o                  corrected payload
//   single_err_o            beat carried a corrected single-bit error
//   double_err_o            beat is uncorrectable (data_o is raw)
//   syndrome_o              Hamming syndrome of the beat
//   clear_i                 zero counters and log
//   single_cnt_o            saturating corrected-error count
//   double_cnt_o            saturating uncorrectable-error count
//   log_valid_o             sticky: an error was seen
//   log_syndrome_o          syndrome of the first logged error
//   log_double_o            first logged error was uncorrectable
module ecc_check_stage #(
  parameter int DataWidth = 64,
  parameter int CntWidth  = 16,
  localparam int P0 = $clog2(DataWidth + 1),
  localparam int ParityWidth =
    ((1 << P0) >= DataWidth + P0 + 1) ? P0 : P0 + 1,
  localparam int CodeWordWidth = DataWidth + ParityWidth
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [CodeWordWidth:0]   cw_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [DataWidth-1:0]     data_o,
  output logic                     single_err_o,
  output logic                     double_err_o,
  output logic [ParityWidth-1:0]   syndrome_o,
  input  logic                     clear_i,
  output logic [CntWidth-1:0]      single_cnt_o,
  output logic [CntWidth-1:0]      double_cnt_o,
  output logic                     log_valid_o,
  output logic [ParityWidth-1:0]   log_syndrome_o,
  output logic                     log_double_o
);

  localparam int CW = CodeWordWidth;
  localparam int PW = ParityWidth;
  localparam logic [PW-1:0] MaxPos = PW'(CW);

  // Data bits sit at non-power-of-two positions, ascending.
  function automatic logic [DataWidth-1:0] extract(
    input logic [CW-1:0] c
  );
    logic [DataWidth-1:0] d;
    int k;
    d = '0;
    k = 0;
    for (int p = 1; p <= CW; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[k] = c[p-1];
        k++;
      end
    end
    return d;
  endfunction

  // ---------------- stage 1: syndrome ----------------
  logic [PW-1:0] syn_c;
  logic          ovr_c;

  always_comb begin
    syn_c = '0;
    for (int p = 1; p <= CW; p++) begin
      for (int i = 0; i < PW; i++) begin
        if (((p >> i) & 1) == 1) begin
          syn_c[i] = syn_c[i] ^ cw_i[p-1];
        end
      end
    end
    ovr_c = ^cw_i;
  end

  logic          s1_valid;
  logic [CW-1:0] s1_cw;
  logic [PW-1:0] s1_syn;
  logic          s1_ovr;
  logic          s2_load;

  // Stage 2 takes a beat whenever it is empty or draining.
  assign s2_load = !valid_o | ready_i;
  assign ready_o = !s1_valid | s2_load;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_cw    <= '0;
      s1_syn   <= '0;
      s1_ovr   <= 1'b0;
    end else if (ready_o) begin
      s1_valid <= valid_i;
      if (valid_i) begin
        s1_cw  <= cw_i[CW-1:0];
        s1_syn <= syn_c;
        s1_ovr <= ovr_c;
      end
    end
  end

  // ---------------- stage 2: classify/correct ----------------
  logic          syn_zero;
  logic          syn_bad;
  logic [CW-1:0] flip;
  logic [CW-1:0] corr;
  logic          single_c;
  logic          double_c;

  assign syn_zero = (s1_syn == '0);
  assign syn_bad  = (s1_syn > MaxPos);

  // Out-of-range syndromes match no position, so nothing flips.
  always_comb begin
    flip = '0;
    for (int p = 1; p <= CW; p++) begin
      flip[p-1] = s1_ovr & (s1_syn == PW'(p));
    end
  end

  assign corr     = s1_cw ^ flip;
  assign single_c = s1_ovr & !syn_bad;
  assign double_c = (s1_ovr & syn_bad) |
                    (!s1_ovr & !syn_zero);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o      <= 1'b0;
      data_o       <= '0;
      single_err_o <= 1'b0;
      double_err_o <= 1'b0;
      syndrome_o   <= '0;
    end else if (s2_load) begin
      valid_o <= s1_valid;
      if (s1_valid) begin
        data_o       <= extract(corr);
        single_err_o <= single_c;
        double_err_o <= double_c;
        syndrome_o   <= s1_syn;
      end
    end
  end

  // ---------------- counters and log ----------------
  logic out_hs;
  assign out_hs = valid_o & ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      single_cnt_o   <= '0;
      double_cnt_o   <= '0;
      log_valid_o    <= 1'b0;
      log_syndrome_o <= '0;
      log_double_o   <= 1'b0;
    end else if (clear_i) begin
      single_cnt_o   <= '0;
      double_cnt_o   <= '0;
      log_valid_o    <= 1'b0;
      log_syndrome_o <= '0;
      log_double_o   <= 1'b0;
    end else if (out_hs) begin
      if (single_err_o && single_cnt_o != '1) begin
        single_cnt_o <= single_cnt_o + CntWidth'(1);
      end
      if (double_err_o && double_cnt_o != '1) begin
        double_cnt_o <= double_cnt_o + CntWidth'(1);
      end
      if (!log_valid_o && (single_err_o | double_err_o)) begin
        log_valid_o    <= 1'b1;
        log_syndrome_o <= syndrome_o;
        log_double_o   <= double_err_o;
      end
    end
  end

endmodule

// File: doc/ecc_check_stage.md
# ecc_check_stage

Pipelined SECDED check-and-correct stage that consumes the extended-Hamming codewords produced by the ECC encoder after storage or transport. It decodes each codeword, corrects single-bit errors, flags double and uncorrectable errors, and presents the recovered data word downstream over a valid/ready handshake. It also keeps saturating error counters and a sticky first-error syndrome log for software scrubbing and diagnostics.

## Interface
- DataWidth, 64, payload width in bits.
- CntWidth, 16, width of each error counter.
- ParityWidth, derived, smallest P with 2^P ≥ DataWidth+P+1 (64→7, 8→4); do not override.
- CodeWordWidth, derived, DataWidth+ParityWidth (64→71, 8→12); do not override.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- valid_i  in  1  input codeword valid.
- ready_o  out  1  stage can accept a codeword.
- cw_i  in  CodeWordWidth+1  {overall parity, codeword}.
- valid_o  out  1  output beat valid.
- ready_i  in  1  downstream accepts the beat.
- data_o  out  DataWidth  corrected payload.
- single_err_o  out  1  beat had a corrected single-bit error.
- double_err_o  out  1  beat is uncorrectable; data_o is raw and unreliable.
- syndrome_o  out  ParityWidth  Hamming syndrome of the beat.
- clear_i  in  1  clears counters and error log.
- single_cnt_o  out  CntWidth  corrected-error count, saturating.
- double_cnt_o  out  CntWidth  uncorrectable-error count, saturating.
- log_valid_o  out  1  sticky: an error has been seen since reset or clear.
- log_syndrome_o  out  ParityWidth  syndrome of the first logged error.
- log_double_o  out  1  the first logged error was uncorrectable.

## Operation
- Codeword layout: positions 1..CodeWordWidth map to cw_i[pos-1]. Power-of-two positions hold the parity bits. Data bits fill the other positions in ascending order, starting at data bit 0. cw_i[CodeWordWidth] is the XOR of cw_i[CodeWordWidth-1:0].
- Stage 1 registers the codeword and computes two values:
  - syndrome s, where s[i] is the XOR of cw_i[pos-1] over every pos with bit i set;
  - overall o, the XOR of all CodeWordWidth+1 bits.
- Stage 2 classifies the beat and registers the result:
  - s=0, o=0: clean.
  - o=1, s=0: error in the overall parity bit. Set single_err; data is unchanged.
  - o=1, 1≤s≤CodeWordWidth: flip position s, extract the data, set single_err.
  - o=1, s>CodeWordWidth: set double_err (invalid syndrome).
  - o=0, s≠0: set double_err.
  - single_err and double_err are never both set.
- Counters and the log update on each output handshake (valid_o & ready_i), once per beat.
  - Counters saturate at 2^CntWidth−1.
  - The log captures only when log_valid_o=0.
- clear_i zeroes the counters and the log. If clear_i and a handshake occur in the same cycle, clear wins and that beat's event is not recorded.

## Timing
- Reset values: every stage valid bit, valid_o, flags, syndrome_o, data_o, both counters and every log output are 0.
- ready_o is 1 while in reset-released idle.
- Latency is 2 cycles from the input handshake to valid_o, with full throughput of one beat per cycle.
- Backpressure:
  - Each stage loads when it is empty or when its contents move on this cycle.
  - ready_o = !stage1_valid | stage2_advances, so ready_o depends combinationally on ready_i.
  - No beat is dropped or duplicated.
- While valid_o=1 and ready_i=0, data_o, the flags and syndrome_o hold stable.
- valid_o never depends on ready_i.
- Reset asserted mid-stream discards in-flight beats immediately and returns all outputs to their reset values.

## Test plan
All cases use DataWidth=8, so CodeWordWidth=12 and cw_i is 13 bits.
- cw_i=13'h0F77 (data 0xFF, clean) → 2 cycles later: data_o=8'hFF, both flags 0, syndrome_o=0, counters unchanged.
- cw_i=13'h0010 (data 0x00, bit idx4 flipped) → data_o=8'h00, single_err_o=1, syndrome_o=5, single_cnt_o=1, log_syndrome_o=5, log_valid_o=1.
- cw_i=13'h1F77 (overall parity bit flipped) → data_o=8'hFF, single_err_o=1, syndrome_o=0.
- Double and invalid-syndrome errors:
  - cw_i=13'h0F74 → double_err_o=1, syndrome_o=3, double_cnt_o=1.
  - Then cw_i=13'h0089 → double_err_o=1, syndrome_o=13 (invalid), double_cnt_o=2.
  - The log still holds syndrome 3.
- Back-to-back stream of 20 random clean and corrupted beats with random ready_i stalls → output order and content match a scoreboard, and held outputs stay stable during stalls.
- Counter and clear behaviour:
  - With CntWidth=2, send 5 single errors → single_cnt_o saturates at 3.
  - Then assert clear_i together with a handshake → counters read 0 next cycle and log_valid_o=0.
